// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
package lsu_pkg;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10,
      SZ_X = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      READ  = 2'b01,
      WRITE = 2'b10,
      RESP  = 2'b11
   } state_e;

   // Memory presents byte a in the MSBs; the LSU works on a little-endian word.
   function automatic logic [31:0] bswap32(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane logic: load extract/extend and sub-word store merge on a little-endian word.
module lsu_lane
   import lsu_pkg::*;
(
   input  logic [31:0] lw,
   input  logic [1:0]  offset,
   input  size_e       size,
   input  logic        uns,
   input  logic [31:0] wdata,
   output logic [31:0] ldata,
   output logic [31:0] mdata
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign byte_sel = lw[{offset, 3'b000} +: 8];
   assign half_sel = lw[{offset[1], 4'b0000} +: 16];

   always_comb begin
      ldata = lw;
      mdata = lw;
      unique case (size)
         SZ_B: begin
            ldata = uns ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            mdata[{offset, 3'b000} +: 8] = wdata[7:0];
         end
         SZ_H: begin
            ldata = uns ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            mdata[{offset[1], 4'b0000} +: 16] = wdata[15:0];
         end
         SZ_W: begin
            ldata = lw;
            mdata = wdata;
         end
         default: begin
            ldata = lw;
            mdata = lw;
         end
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit: request latch, error decode and the IDLE/READ/WRITE/RESP sequencer
// driving a single-ported word memory.
module mem_lsu
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_SIZE = 512
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] mem_a,
   output logic        mem_we,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd
);

   localparam logic [31:0] MEM_BYTES = 32'(MEM_SIZE) << 2;

   state_e      state_q, state_d;
   logic        we_q;
   size_e       size_q;
   logic        uns_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] lw_q, lw_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   size_e       req_sz;
   logic        req_err;
   logic        accept;
   logic [31:0] addr_al;
   logic [31:0] lane_lw;
   logic [31:0] ldata;
   logic [31:0] mdata;

   assign req_sz  = size_e'(req_size);
   assign accept  = req_valid && (state_q == IDLE);
   assign addr_al = {addr_q[31:2], 2'b00};

   assign req_err = (req_sz == SZ_X)
                  || ((req_sz == SZ_H) && req_addr[0])
                  || ((req_sz == SZ_W) && (req_addr[1:0] != 2'b00))
                  || (req_addr >= MEM_BYTES);

   // READ extracts straight from memory; WRITE merges into the word captured in READ.
   assign lane_lw = (state_q == READ) ? bswap32(mem_rd) : lw_q;

   lsu_lane u_lane (
      .lw     (lane_lw),
      .offset (addr_q[1:0]),
      .size   (size_q),
      .uns    (uns_q),
      .wdata  (wdata_q),
      .ldata  (ldata),
      .mdata  (mdata)
   );

   always_comb begin
      state_d   = state_q;
      lw_d      = lw_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      mem_a     = 32'h0;
      mem_we    = 1'b0;
      mem_wd    = 32'h0;
      unique case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (req_err) begin
                  state_d = RESP;
                  rdata_d = 32'h0;
                  err_d   = 1'b1;
               end else if (req_we && (req_sz == SZ_W)) begin
                  state_d = WRITE;
               end else begin
                  state_d = READ;
               end
            end
         end
         READ: begin
            mem_a = addr_al;
            lw_d  = lane_lw;
            if (we_q) begin
               state_d = WRITE;
            end else begin
               state_d = RESP;
               rdata_d = ldata;
               err_d   = 1'b0;
            end
         end
         WRITE: begin
            mem_we  = 1'b1;
            mem_a   = addr_al;
            mem_wd  = mdata;
            state_d = RESP;
            rdata_d = 32'h0;
            err_d   = 1'b0;
         end
         RESP: begin
            rsp_valid = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         size_q  <= SZ_B;
         uns_q   <= 1'b0;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         lw_q    <= 32'h0;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         lw_q    <= lw_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         if (accept) begin
            we_q    <= req_we;
            size_q  <= req_sz;
            uns_q   <= req_unsigned;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end
      end
   end

   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed scenarios plus random traffic against a
// byte-array reference model.
module tb_mem_lsu;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] mem_a;
   logic        mem_we;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;

   logic [7:0]  mem_b [0:2047];
   logic [7:0]  ref_b [0:2047];
   logic [10:0] ia;

   int checks = 0;
   int errors = 0;
   int we_total = 0;

   mem_lsu #(.MEM_SIZE(512)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .mem_a        (mem_a),
      .mem_we       (mem_we),
      .mem_wd       (mem_wd),
      .mem_rd       (mem_rd)
   );

   always #5 clk = ~clk;

   assign ia     = mem_a[10:0];
   assign mem_rd = {mem_b[ia], mem_b[ia + 11'd1], mem_b[ia + 11'd2], mem_b[ia + 11'd3]};

   always @(posedge clk) begin
      if (mem_we) begin
         mem_b[ia]         <= mem_wd[7:0];
         mem_b[ia + 11'd1] <= mem_wd[15:8];
         mem_b[ia + 11'd2] <= mem_wd[23:16];
         mem_b[ia + 11'd3] <= mem_wd[31:24];
         we_total          <= we_total + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_load(input int a, input logic [1:0] sz, input logic uns);
      logic [7:0]  v;
      logic [15:0] h;
      case (sz)
         2'b00: begin
            v = ref_b[a];
            return uns ? {24'h0, v} : {{24{v[7]}}, v};
         end
         2'b01: begin
            h = {ref_b[a + 1], ref_b[a]};
            return uns ? {16'h0, h} : {{16{h[15]}}, h};
         end
         default: return {ref_b[a + 3], ref_b[a + 2], ref_b[a + 1], ref_b[a]};
      endcase
   endfunction

   task automatic ref_store(input int a, input logic [1:0] sz, input logic [31:0] wd);
      ref_b[a] = wd[7:0];
      if (sz != 2'b00) ref_b[a + 1] = wd[15:8];
      if (sz == 2'b10) begin
         ref_b[a + 2] = wd[23:16];
         ref_b[a + 3] = wd[31:24];
      end
   endtask

   task automatic mem_compare(input string tag);
      int diffs = 0;
      for (int i = 0; i < 2048; i++) if (mem_b[i] !== ref_b[i]) diffs++;
      check({tag, " mem"}, 32'(diffs), 32'd0);
   endtask

   // One complete transaction: latency, error, data, write count and memory contents.
   task automatic do_op(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input string tag,
                        output logic [31:0] rd);
      logic        e;
      int          lat_exp, we_exp, cyc, wcnt, ai;
      logic [31:0] rexp;
      e  = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)
           || (a >= 32'd2048);
      ai = int'(a[10:0]);
      rexp = 32'h0;
      if (e) begin
         lat_exp = 1; we_exp = 0;
      end else if (we) begin
         lat_exp = (sz == 2'b10) ? 2 : 3; we_exp = 1;
      end else begin
         lat_exp = 2; we_exp = 0; rexp = ref_load(ai, sz, uns);
      end
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
      req_addr = a; req_wdata = wd;
      check({tag, " ready"}, 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_we = $urandom;
      cyc = 1; wcnt = 0;
      while (!rsp_valid && cyc < 8) begin
         if (mem_we) wcnt++;
         @(posedge clk); #1;
         cyc++;
      end
      rd = rsp_rdata;
      check({tag, " latency"}, 32'(cyc), 32'(lat_exp));
      check({tag, " err"}, 32'(rsp_err), 32'(e));
      check({tag, " rdata"}, rsp_rdata, rexp);
      check({tag, " we pulses"}, 32'(wcnt), 32'(we_exp));
      @(posedge clk); #1;
      check({tag, " rsp width"}, 32'(rsp_valid), 32'd0);
      if (!e && we) ref_store(ai, sz, wd);
      mem_compare(tag);
   endtask

   initial begin
      logic [31:0] rd, rexp;
      int          w0, acc, nrsp, last, n, wide;
      logic        prev;
      for (int i = 0; i < 2048; i++) begin
         mem_b[i] = 8'h0;
         ref_b[i] = 8'h0;
      end

      #12;
      check("reset ready", 32'(req_ready), 32'd1);
      check("reset rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset rdata", rsp_rdata, 32'h0);
      check("reset err", 32'(rsp_err), 32'd0);
      check("reset mem_we", 32'(mem_we), 32'd0);
      check("reset mem_a", mem_a, 32'h0);
      check("reset mem_wd", mem_wd, 32'h0);
      @(negedge clk); rst_n = 1'b1;

      do_op(1'b1, 2'b10, 1'b0, 32'h100, 32'h11223344, "sw", rd);
      do_op(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, "lw", rd);
      check("lw const", rd, 32'h11223344);
      do_op(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, "lb", rd);
      check("lb const", rd, 32'h00000033);
      do_op(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, "lbu", rd);
      check("lbu const", rd, 32'h00000011);
      do_op(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, "lh", rd);
      check("lh const", rd, 32'h00001122);

      do_op(1'b1, 2'b00, 1'b0, 32'h102, 32'h00000080, "sb", rd);
      do_op(1'b0, 2'b00, 1'b0, 32'h102, 32'h0, "lb neg", rd);
      check("lb neg const", rd, 32'hFFFFFF80);
      do_op(1'b0, 2'b00, 1'b1, 32'h102, 32'h0, "lbu 80", rd);
      check("lbu 80 const", rd, 32'h00000080);
      do_op(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, "lw merged", rd);
      check("lw merged const", rd, 32'h11803344);

      w0 = we_total;
      do_op(1'b0, 2'b01, 1'b0, 32'h103, 32'h0, "err lh", rd);
      do_op(1'b1, 2'b10, 1'b0, 32'h102, 32'hDEADBEEF, "err sw", rd);
      do_op(1'b1, 2'b11, 1'b0, 32'h100, 32'hDEADBEEF, "err size", rd);
      do_op(1'b0, 2'b10, 1'b0, 32'h800, 32'h0, "err range", rd);
      check("err no writes", 32'(we_total), 32'(w0));

      // Reset while the half-word RMW is in its READ cycle.
      w0 = we_total;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
      req_addr = 32'h100; req_wdata = 32'h0000BEEF;
      @(posedge clk); #1;
      req_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rst mid ready", 32'(req_ready), 32'd1);
      check("rst mid mem_we", 32'(mem_we), 32'd0);
      check("rst mid mem_a", mem_a, 32'h0);
      @(negedge clk); rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst no write", 32'(we_total), 32'(w0));
      do_op(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, "lw after rst", rd);
      check("lw after rst const", rd, 32'h11803344);

      // Back-to-back loads with req_valid held high.
      rexp = ref_load(256, 2'b10, 1'b0);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
      req_addr = 32'h100;
      acc = 0; nrsp = 0; last = 0; n = 0; wide = 0; prev = 1'b0;
      while (nrsp < 3 && n < 40) begin
         if (rsp_valid) begin
            nrsp++;
            check("b2b rdata", rsp_rdata, rexp);
            if (prev) wide++;
         end
         prev = rsp_valid;
         if (req_valid && req_ready) begin
            if (acc > 0) check("b2b accept gap", 32'(n - last), 32'd3);
            last = n;
            acc++;
         end
         @(posedge clk); #1;
         if (acc >= 3) req_valid = 1'b0;
         @(negedge clk);
         n++;
      end
      check("b2b rsp count", 32'(nrsp), 32'd3);
      check("b2b accept count", 32'(acc), 32'd3);
      check("b2b wide pulses", 32'(wide), 32'd0);
      check("b2b last width", 32'(rsp_valid), 32'd0);

      for (int k = 0; k < 40; k++) begin
         logic [1:0]  sz;
         logic [31:0] a;
         int          r;
         r  = int'($urandom % 8);
         sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r == 6) ? 2'b10 : 2'b11;
         if ($urandom % 10 == 0) a = 32'h800 + ($urandom % 1024);
         else a = 32'h100 + ($urandom % 64);
         if ($urandom % 2 == 1) begin
            if (sz == 2'b01) a[0] = 1'b0;
            if (sz == 2'b10) a[1:0] = 2'b00;
         end
         do_op(1'($urandom % 2), sz, 1'($urandom % 2), a, $urandom, "rand", rd);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
